// File: rtl/riscv_lsu_if.sv
// Core/memory signal bundle for the RISC-V load/store unit.
// slave modport: the LSU itself; master modport: the core+memory environment.
interface riscv_lsu_if;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;
    logic        timeout_o;
    logic        misalign_o;

    modport slave (
        input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        input  mem_rd_i, mem_ready_i,
        output core_rd_o, core_stall_o, mem_req_o, mem_we_o, mem_be_o,
        output mem_addr_o, mem_wd_o, timeout_o, misalign_o
    );

    modport master (
        output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        output mem_rd_i, mem_ready_i,
        input  core_rd_o, core_stall_o, mem_req_o, mem_we_o, mem_be_o,
        input  mem_addr_o, mem_wd_o, timeout_o, misalign_o
    );
endinterface

// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: IDLE -> BUSY -> DONE handshake between core and a
// single-port memory, with byte-lane steering and load extension.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (misaligned H/W accesses are
// aborted without touching memory and flagged on misalign_o).
module riscv_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 0  // 0 = wait forever
) (
    input logic        clk_i,
    input logic        rst_i,
    riscv_lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rd_q, rd_d;
    logic [31:0] cnt_q, cnt_d;
    logic        to_q, to_d;
    logic        mis_q, mis_d;

    logic        stall, mreq;
    logic        req_b, req_h, ld_b, ld_h, misal;
    logic [3:0]  req_be;
    logic [31:0] req_wd, ld_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Decode the incoming core request into byte enables and replicated data.
    // Sizes 3/6/7 fall through to word.
    always_comb begin
        req_b  = (bus.core_size_i == 3'd0) || (bus.core_size_i == 3'd4);
        req_h  = (bus.core_size_i == 3'd1) || (bus.core_size_i == 3'd5);
        req_be = 4'b1111;
        req_wd = bus.core_wd_i;
        misal  = 1'b0;
        if (req_b) begin
            req_be = 4'b0001 << bus.core_addr_i[1:0];
            req_wd = {4{bus.core_wd_i[7:0]}};
        end else if (req_h) begin
            req_be = bus.core_addr_i[1] ? 4'b1100 : 4'b0011;
            req_wd = {2{bus.core_wd_i[15:0]}};
        end
`ifdef LSU_MISALIGN_CHECK_EN
        misal = req_h ? bus.core_addr_i[0] : (!req_b && (bus.core_addr_i[1:0] != 2'b00));
`endif
    end

    // Extract and extend the addressed lane of the returned memory word.
    always_comb begin
        ld_b    = (size_q == 3'd0) || (size_q == 3'd4);
        ld_h    = (size_q == 3'd1) || (size_q == 3'd5);
        ld_byte = 8'(bus.mem_rd_i >> {addr_q[1:0], 3'b000});
        ld_half = addr_q[1] ? bus.mem_rd_i[31:16] : bus.mem_rd_i[15:0];
        ld_ext  = bus.mem_rd_i;
        if (ld_b)
            ld_ext = size_q[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        else if (ld_h)
            ld_ext = size_q[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        be_d    = be_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        mis_d   = 1'b0;
        stall   = 1'b0;
        mreq    = 1'b0;
        case (state_q)
            IDLE: if (bus.core_req_i) begin
                stall  = 1'b1;
                we_d   = bus.core_we_i;
                size_d = bus.core_size_i;
                addr_d = bus.core_addr_i;
                wd_d   = req_wd;
                be_d   = req_be;
                cnt_d  = 32'd0;
                if (misal) begin
                    state_d = DONE;
                    mis_d   = 1'b1;
                    rd_d    = 32'd0;
                end else begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                mreq  = 1'b1;
                // A ready arriving on the last allowed cycle still completes normally.
                if (bus.mem_ready_i) begin
                    rd_d    = we_q ? 32'd0 : ld_ext;
                    state_d = DONE;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == TIMEOUT_CYCLES - 1) begin
                    rd_d    = 32'd0;
                    to_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and captured-request registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= 32'd0;
            wd_q    <= 32'd0;
            be_q    <= 4'd0;
            rd_q    <= 32'd0;
            cnt_q   <= 32'd0;
            to_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            mis_q   <= mis_d;
        end
    end

    // Reset gates the combinational handshake so the core PC reset can proceed
    // and an abandoned access never drives memory.
    assign bus.core_stall_o = stall & ~rst_i;
    assign bus.mem_req_o    = mreq & ~rst_i;
    assign bus.mem_we_o     = we_q;
    assign bus.mem_be_o     = be_q;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_wd_o     = wd_q;
    assign bus.core_rd_o    = rd_q;
    assign bus.timeout_o    = to_q;
    assign bus.misalign_o   = mis_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu (TIMEOUT_CYCLES=4).
module tb_riscv_lsu;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks = 0;
    int   failures = 0;

    riscv_lsu_if bus();

    riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Zero-wait access: ready is held high the whole time (ignored outside BUSY).
    task automatic access(input string nm, input logic we, input logic [2:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] mrd, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic [31:0] erd);
        int stalls;
        stalls = 0;
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = we;
        bus.core_size_i = sz;
        bus.core_addr_i = addr;
        bus.core_wd_i   = wd;
        bus.mem_rd_i    = mrd;
        bus.mem_ready_i = 1'b1;
        #1;
        if (bus.core_stall_o) stalls++;
        chk({nm, ".idle_req"}, 32'(bus.mem_req_o), 32'd0);
        step();
        if (bus.core_stall_o) stalls++;
        chk({nm, ".busy_req"}, 32'(bus.mem_req_o), 32'd1);
        chk({nm, ".we"}, 32'(bus.mem_we_o), 32'(we));
        chk({nm, ".be"}, 32'(bus.mem_be_o), 32'(ebe));
        chk({nm, ".addr"}, bus.mem_addr_o, addr);
        if (we) chk({nm, ".wd"}, bus.mem_wd_o, ewd);
        step();
        if (bus.core_stall_o) stalls++;
        chk({nm, ".done_req"}, 32'(bus.mem_req_o), 32'd0);
        chk({nm, ".rd"}, bus.core_rd_o, erd);
        chk({nm, ".stalls"}, 32'(stalls), 32'd2);
        bus.core_req_i = 1'b0;
        step();
    endtask

    initial begin
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = 3'd2;
        bus.core_addr_i = 32'h100;
        bus.core_wd_i   = 32'd0;
        bus.mem_rd_i    = 32'd0;
        bus.mem_ready_i = 1'b1;
        step();
        step();
        // Reset state, with a request pending to prove stall stays low.
        chk("rst.stall", 32'(bus.core_stall_o), 32'd0);
        chk("rst.mem_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst.timeout", 32'(bus.timeout_o), 32'd0);
        chk("rst.misalign", 32'(bus.misalign_o), 32'd0);
        chk("rst.rd", bus.core_rd_o, 32'd0);
        bus.core_req_i = 1'b0;
        rst_i = 1'b0;
        step();
        // Ready while idle must do nothing.
        chk("idle_ready.stall", 32'(bus.core_stall_o), 32'd0);
        chk("idle_ready.req", 32'(bus.mem_req_o), 32'd0);
        step();
        chk("idle_ready.req2", 32'(bus.mem_req_o), 32'd0);

        access("lw",   1'b0, 3'd2, 32'h100, 32'd0,        32'hDEADBEEF, 4'b1111, 32'd0,        32'hDEADBEEF);
        access("lb",   1'b0, 3'd0, 32'h103, 32'd0,        32'h80FF0000, 4'b1000, 32'd0,        32'hFFFFFF80);
        access("lbu",  1'b0, 3'd4, 32'h103, 32'd0,        32'h80FF0000, 4'b1000, 32'd0,        32'h00000080);
        access("lh",   1'b0, 3'd1, 32'h102, 32'd0,        32'h80FF0000, 4'b1100, 32'd0,        32'hFFFF80FF);
        access("lhu",  1'b0, 3'd5, 32'h102, 32'd0,        32'h80FF0000, 4'b1100, 32'd0,        32'h000080FF);
        access("sb",   1'b1, 3'd0, 32'h201, 32'h000000AB, 32'h12345678, 4'b0010, 32'hABABABAB, 32'd0);
        access("sh",   1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'h12345678, 4'b1100, 32'hABCDABCD, 32'd0);
        access("sw",   1'b1, 3'd2, 32'h300, 32'hCAFEF00D, 32'h12345678, 4'b1111, 32'hCAFEF00D, 32'd0);
        access("lsz7", 1'b0, 3'd7, 32'h104, 32'd0,        32'h0BADC0DE, 4'b1111, 32'd0,        32'h0BADC0DE);
        access("lb0",  1'b0, 3'd0, 32'h100, 32'd0,        32'hFFFFFF7F, 4'b0001, 32'd0,        32'h0000007F);
        access("lh0",  1'b0, 3'd1, 32'h100, 32'd0,        32'h00008001, 4'b0011, 32'd0,        32'hFFFF8001);

        // Misaligned word.
`ifdef LSU_MISALIGN_CHECK_EN
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = 3'd2;
        bus.core_addr_i = 32'h102;
        #1;
        chk("mis.stall", 32'(bus.core_stall_o), 32'd1);
        chk("mis.req", 32'(bus.mem_req_o), 32'd0);
        step();
        chk("mis.req_done", 32'(bus.mem_req_o), 32'd0);
        chk("mis.stall_done", 32'(bus.core_stall_o), 32'd0);
        chk("mis.pulse", 32'(bus.misalign_o), 32'd1);
        chk("mis.rd", bus.core_rd_o, 32'd0);
        bus.core_req_i = 1'b0;
        step();
        chk("mis.pulse_end", 32'(bus.misalign_o), 32'd0);
`else
        access("lw_mis", 1'b0, 3'd2, 32'h102, 32'd0, 32'h11223344, 4'b1111, 32'd0, 32'h11223344);
        chk("mis.tied0", 32'(bus.misalign_o), 32'd0);
`endif

        // Timeout: ready never arrives, four BUSY cycles then abort.
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = 3'd2;
        bus.core_addr_i = 32'h400;
        bus.mem_ready_i = 1'b0;
        bus.mem_rd_i    = 32'hFFFFFFFF;
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to.req%0d", i), 32'(bus.mem_req_o), 32'd1);
            chk($sformatf("to.pulse%0d", i), 32'(bus.timeout_o), 32'd0);
            step();
        end
        chk("to.req_drop", 32'(bus.mem_req_o), 32'd0);
        chk("to.pulse", 32'(bus.timeout_o), 32'd1);
        chk("to.stall", 32'(bus.core_stall_o), 32'd0);
        chk("to.rd", bus.core_rd_o, 32'd0);
        bus.core_req_i = 1'b0;
        step();
        chk("to.pulse_end", 32'(bus.timeout_o), 32'd0);

        // Ready on the final allowed cycle wins over timeout.
        bus.core_req_i = 1'b1;
        step();
        for (int i = 0; i < 3; i++) step();
        bus.mem_ready_i = 1'b1;
        bus.mem_rd_i    = 32'h55AA55AA;
        step();
        chk("late.pulse", 32'(bus.timeout_o), 32'd0);
        chk("late.rd", bus.core_rd_o, 32'h55AA55AA);
        chk("late.stall", 32'(bus.core_stall_o), 32'd0);
        bus.core_req_i = 1'b0;
        step();

        // Reset in the middle of BUSY abandons the access.
        bus.mem_ready_i = 1'b0;
        bus.core_req_i  = 1'b1;
        step();
        chk("rbusy.req_before", 32'(bus.mem_req_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("rbusy.req_in_rst", 32'(bus.mem_req_o), 32'd0);
        chk("rbusy.stall_in_rst", 32'(bus.core_stall_o), 32'd0);
        bus.core_req_i = 1'b0;
        step();
        rst_i = 1'b0;
        #1;
        chk("rbusy.req_after", 32'(bus.mem_req_o), 32'd0);
        chk("rbusy.stall_after", 32'(bus.core_stall_o), 32'd0);
        chk("rbusy.rd", bus.core_rd_o, 32'd0);
        step();
        chk("rbusy.idle_req", 32'(bus.mem_req_o), 32'd0);
        access("post_rst", 1'b0, 3'd2, 32'h500, 32'd0, 32'h600DF00D, 4'b1111, 32'd0, 32'h600DF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
